// File: rtl/axi2memrq.sv
// axi2memrq: AXI4-Lite responder that turns each read or write into one
// request on the simple memory-request (memrq) interface.
// One transaction is in flight at a time. Reads and writes alternate when both are pending.
// Optional feature: define AXI2MEMRQ_TIMEOUT_EN to answer SLVERR when memory
// never responds within TIMEOUT_CYCLES cycles of MEM_WAIT.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a full write (AW+W) or read (AR) buffer
// MEM_WAIT | request issued, waiting for response_enable (or timeout)
// RESP     | B or R response presented, waiting for the master's ready
module axi2memrq #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic [31:0] axi_araddr,
    input  logic [2:0]  axi_arprot,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic        request_enable,
    output logic        req_mode,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic        response_enable,
    input  logic [31:0] resp_data
);

    // memrq mode encoding shared with the memory side
    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT, S_RESP} state_t;

    state_t      state_q;
    logic        aw_full_q, w_full_q, ar_full_q;
    logic [31:0] awaddr_q, wdata_q, araddr_q;
    logic [3:0]  wstrb_q;
    logic        prio_read_q;
    logic        cur_read_q;

    logic aw_hs, w_hs, ar_hs;
    logic wr_done, rd_done;
    logic wr_pend, pick_read;
    logic aw_full_d, w_full_d, ar_full_d;

    // Protection bits carry no meaning for memrq targets.
    logic unused_prot;
    assign unused_prot = ^{axi_awprot, axi_arprot};

    assign aw_hs   = axi_awvalid & axi_awready;
    assign w_hs    = axi_wvalid  & axi_wready;
    assign ar_hs   = axi_arvalid & axi_arready;
    assign wr_done = (state_q == S_RESP) & axi_bvalid & axi_bready;
    assign rd_done = (state_q == S_RESP) & axi_rvalid & axi_rready;

    // A handshake needs an empty buffer and a release needs a full one, so the two never coincide.
    assign aw_full_d = aw_hs ? 1'b1 : (wr_done ? 1'b0 : aw_full_q);
    assign w_full_d  = w_hs  ? 1'b1 : (wr_done ? 1'b0 : w_full_q);
    assign ar_full_d = ar_hs ? 1'b1 : (rd_done ? 1'b0 : ar_full_q);

    assign wr_pend   = aw_full_q & w_full_q;
    assign pick_read = ar_full_q & (~wr_pend | prio_read_q);

`ifdef AXI2MEMRQ_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;
    logic        tmo_hit;
    assign tmo_hit = (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

    // One-entry capture buffers; ready mirrors "buffer empty" one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_q   <= 1'b0;
            w_full_q    <= 1'b0;
            ar_full_q   <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            araddr_q    <= '0;
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_arready <= 1'b0;
        end else begin
            aw_full_q   <= aw_full_d;
            w_full_q    <= w_full_d;
            ar_full_q   <= ar_full_d;
            axi_awready <= ~aw_full_d;
            axi_wready  <= ~w_full_d;
            axi_arready <= ~ar_full_d;
            if (aw_hs) awaddr_q <= axi_awaddr;
            if (w_hs) begin
                wdata_q <= axi_wdata;
                wstrb_q <= axi_wstrb;
            end
            if (ar_hs) araddr_q <= axi_araddr;
        end
    end

    // Transaction FSM: arbitrate, issue the memrq pulse, collect the response, hand it back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            prio_read_q    <= 1'b1;
            cur_read_q     <= 1'b0;
            request_enable <= 1'b0;
            req_mode       <= 1'b0;
            req_addr       <= '0;
            req_wdata      <= '0;
            req_wstrb      <= '0;
            axi_bresp      <= 2'b00;
            axi_bvalid     <= 1'b0;
            axi_rdata      <= '0;
            axi_rresp      <= 2'b00;
            axi_rvalid     <= 1'b0;
`ifdef AXI2MEMRQ_TIMEOUT_EN
            tmo_cnt_q      <= '0;
`endif
        end else begin
            request_enable <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (wr_pend | ar_full_q) begin
                        if (wr_pend & ar_full_q) prio_read_q <= ~prio_read_q;
                        cur_read_q     <= pick_read;
                        request_enable <= 1'b1;
                        if (pick_read) begin
                            req_mode <= MEMREQ_READ;
                            req_addr <= araddr_q - BASE_ADDR;
                        end else begin
                            req_mode  <= MEMREQ_WRITE;
                            req_addr  <= awaddr_q - BASE_ADDR;
                            req_wdata <= wdata_q;
                            req_wstrb <= wstrb_q;
                        end
`ifdef AXI2MEMRQ_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                        state_q <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    // A response in the issue cycle itself cannot belong to this request.
                    if (response_enable & ~request_enable) begin
                        if (cur_read_q) begin
                            axi_rdata  <= resp_data;
                            axi_rresp  <= 2'b00;
                            axi_rvalid <= 1'b1;
                        end else begin
                            axi_bresp  <= 2'b00;
                            axi_bvalid <= 1'b1;
                        end
                        state_q <= S_RESP;
                    end
`ifdef AXI2MEMRQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        if (cur_read_q) begin
                            axi_rdata  <= '0;
                            axi_rresp  <= 2'b10;
                            axi_rvalid <= 1'b1;
                        end else begin
                            axi_bresp  <= 2'b10;
                            axi_bvalid <= 1'b1;
                        end
                        state_q <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    end
`endif
                end
                S_RESP: begin
                    if (rd_done) begin
                        axi_rvalid <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (wr_done) begin
                        axi_bvalid <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi2memrq.sv
// Directed bench for axi2memrq: hand-computed expectations for write/read
// flow, arbitration, back-pressure, ignored responses, reset and timeout.
module tb_axi2memrq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
    logic [2:0]  axi_awprot, axi_arprot;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [3:0]  axi_wstrb;
    logic [1:0]  axi_bresp, axi_rresp;
    logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
    logic        axi_rvalid, axi_rready;
    logic        request_enable, req_mode;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        response_enable;
    logic [31:0] resp_data;

    int n_tests = 0;
    int n_fail  = 0;
    int req_cnt = 0;
    int base_cnt;

    logic        got_mode;
    logic [31:0] got_addr, got_wdata;
    logic [3:0]  got_wstrb;

    axi2memrq #(.BASE_ADDR(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .response_enable(response_enable), .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    // count every cycle the request pulse is high
    always @(posedge clk) if (request_enable) req_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rvalid();
        int n = 0;
        while (!axi_rvalid && n < 60) begin tick(); n++; end
        chk("rvalid_wait", {31'd0, axi_rvalid}, 32'd1);
    endtask

    task automatic wait_bvalid();
        int n = 0;
        while (!axi_bvalid && n < 60) begin tick(); n++; end
        chk("bvalid_wait", {31'd0, axi_bvalid}, 32'd1);
    endtask

    // wait for the request pulse, record it, answer after lat cycles
    task automatic mem_serve(input int lat, input logic [31:0] data);
        int n = 0;
        while (!request_enable && n < 60) begin tick(); n++; end
        chk("req_seen", {31'd0, request_enable}, 32'd1);
        got_mode  = req_mode;
        got_addr  = req_addr;
        got_wdata = req_wdata;
        got_wstrb = req_wstrb;
        resp_data = data;
        repeat (lat) tick();
        response_enable = 1'b1;
        tick();
        response_enable = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] a);
        axi_awaddr = a; axi_awvalid = 1'b1; tick(); axi_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        axi_araddr = a; axi_arvalid = 1'b1; tick(); axi_arvalid = 1'b0;
    endtask

    task automatic r_hs();
        axi_rready = 1'b1; tick(); axi_rready = 1'b0;
    endtask

    task automatic b_hs();
        axi_bready = 1'b1; tick(); axi_bready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; repeat (3) tick(); rst = 1'b0; tick();
    endtask

    initial begin
        rst = 1'b1;
        axi_awaddr = '0; axi_awprot = '0; axi_awvalid = 1'b0;
        axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0; axi_bready = 1'b0;
        axi_araddr = '0; axi_arprot = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
        response_enable = 1'b0; resp_data = '0;

        // reset values
        repeat (3) tick();
        chk("rst_ready", {29'd0, axi_awready, axi_wready, axi_arready}, 32'd0);
        chk("rst_valid", {29'd0, axi_bvalid, axi_rvalid, request_enable}, 32'd0);
        chk("rst_req",   req_addr | req_wdata | {28'd0, req_wstrb} | {31'd0, req_mode}, 32'd0);
        chk("rst_resp",  axi_rdata | {28'd0, axi_bresp, axi_rresp}, 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", {29'd0, axi_awready, axi_wready, axi_arready}, 32'd7);

        // AW+W same cycle, latency 1
        base_cnt = req_cnt;
        axi_awaddr = 32'h100; axi_awvalid = 1'b1;
        axi_wdata = 32'hDEADBEEF; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        chk("aw_w_ready_low", {30'd0, axi_awready, axi_wready}, 32'd0);
        mem_serve(1, 32'h0);
        chk("w1_mode", {31'd0, got_mode}, 32'd1);
        chk("w1_addr", got_addr, 32'h100);
        chk("w1_wdata", got_wdata, 32'hDEADBEEF);
        chk("w1_wstrb", {28'd0, got_wstrb}, 32'hF);
        chk("w1_bvalid", {31'd0, axi_bvalid}, 32'd1);
        chk("w1_bresp", {30'd0, axi_bresp}, 32'd0);
        chk("w1_pulses", req_cnt - base_cnt, 32'd1);
        b_hs();
        chk("w1_b_clear", {31'd0, axi_bvalid}, 32'd0);
        chk("w1_ready_back", {30'd0, axi_awready, axi_wready}, 32'd3);

        // W three cycles before AW
        base_cnt = req_cnt;
        axi_wdata = 32'h12345678; axi_wstrb = 4'h3; axi_wvalid = 1'b1;
        tick();
        axi_wvalid = 1'b0;
        repeat (3) tick();
        chk("w2_no_req", req_cnt - base_cnt, 32'd0);
        chk("w2_ready", {30'd0, axi_awready, axi_wready}, 32'd2);
        send_aw(32'h8);
        mem_serve(2, 32'h0);
        chk("w2_mode", {31'd0, got_mode}, 32'd1);
        chk("w2_addr", got_addr, 32'h8);
        chk("w2_wdata", got_wdata, 32'h12345678);
        chk("w2_wstrb", {28'd0, got_wstrb}, 32'h3);
        chk("w2_pulses", req_cnt - base_cnt, 32'd1);
        wait_bvalid();
        b_hs();

        // AR latency 5, request one cycle after capture
        axi_araddr = 32'h40; axi_arvalid = 1'b1;
        tick();
        axi_arvalid = 1'b0;
        chk("r1_captured", {30'd0, axi_arready, request_enable}, 32'd0);
        tick();
        chk("r1_req_next", {31'd0, request_enable}, 32'd1);
        mem_serve(5, 32'hCAFEF00D);
        chk("r1_mode", {31'd0, got_mode}, 32'd0);
        chk("r1_addr", got_addr, 32'h40);
        wait_rvalid();
        chk("r1_rdata", axi_rdata, 32'hCAFEF00D);
        chk("r1_rresp", {30'd0, axi_rresp}, 32'd0);
        r_hs();
        chk("r1_clear", {30'd0, axi_rvalid, axi_arready}, 32'd1);

        // response in the issue cycle is ignored; stray response in IDLE too
        response_enable = 1'b1; resp_data = 32'h5555AAAA; tick(); response_enable = 1'b0;
        chk("idle_resp_ignored", {30'd0, axi_rvalid, axi_bvalid}, 32'd0);
        send_ar(32'h44);
        while (!request_enable) tick();
        response_enable = 1'b1; resp_data = 32'hBAD0BAD0; tick(); response_enable = 1'b0;
        chk("issue_resp_ignored", {31'd0, axi_rvalid}, 32'd0);
        tick();
        response_enable = 1'b1; resp_data = 32'h0000_0044; tick(); response_enable = 1'b0;
        chk("r2_rdata", axi_rdata, 32'h0000_0044);
        r_hs();

        // arbitration: read first after reset, then write first
        do_reset();
        axi_awaddr = 32'h200; axi_awvalid = 1'b1;
        axi_wdata = 32'hA5A5A5A5; axi_wstrb = 4'hC; axi_wvalid = 1'b1;
        axi_araddr = 32'h300; axi_arvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
        mem_serve(1, 32'h0000_0300);
        chk("arb1_first_read", {31'd0, got_mode}, 32'd0);
        wait_rvalid(); r_hs();
        mem_serve(1, 32'h0);
        chk("arb1_then_write", {31'd0, got_mode}, 32'd1);
        chk("arb1_waddr", got_addr, 32'h200);
        wait_bvalid(); b_hs();
        axi_awaddr = 32'h204; axi_awvalid = 1'b1;
        axi_wdata = 32'h0F0F0F0F; axi_wstrb = 4'h1; axi_wvalid = 1'b1;
        axi_araddr = 32'h304; axi_arvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
        mem_serve(1, 32'h0);
        chk("arb2_first_write", {31'd0, got_mode}, 32'd1);
        chk("arb2_waddr", got_addr, 32'h204);
        wait_bvalid(); b_hs();
        mem_serve(1, 32'h0000_0304);
        chk("arb2_then_read", {31'd0, got_mode}, 32'd0);
        wait_rvalid(); r_hs();

        // rready held low for 4 cycles, second AR waiting meanwhile
        send_ar(32'h400);
        mem_serve(2, 32'h11112222);
        wait_rvalid();
        base_cnt = req_cnt;
        axi_araddr = 32'h500; axi_arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_rvalid", {31'd0, axi_rvalid}, 32'd1);
            chk("stall_rdata", axi_rdata, 32'h11112222);
            chk("stall_arready", {31'd0, axi_arready}, 32'd0);
        end
        chk("stall_no_req", req_cnt - base_cnt, 32'd0);
        r_hs();
        chk("stall_released", {30'd0, axi_rvalid, axi_arready}, 32'd1);
        tick();
        axi_arvalid = 1'b0;
        mem_serve(1, 32'h33334444);
        chk("stall_second_addr", got_addr, 32'h500);
        wait_rvalid();
        chk("stall_second_data", axi_rdata, 32'h33334444);
        r_hs();

        // reset mid-transaction, late response ignored
        send_ar(32'h600);
        while (!request_enable) tick();
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_outputs", {28'd0, axi_rvalid, axi_arready, request_enable, axi_bvalid}, 32'd0);
        response_enable = 1'b1; resp_data = 32'h77777777; tick(); response_enable = 1'b0;
        tick();
        chk("midrst_late_resp", {31'd0, axi_rvalid}, 32'd0);
        chk("midrst_rdata", axi_rdata, 32'd0);
        chk("midrst_ready", {31'd0, axi_arready}, 32'd1);

`ifdef AXI2MEMRQ_TIMEOUT_EN
        begin
            int n;
            send_ar(32'h60);
            mem_serve(1, 32'hABCD1234);
            wait_rvalid(); r_hs();
            send_ar(32'h80);
            n = 0;
            while (!request_enable && n < 60) begin tick(); n++; end
            n = 0;
            while (!axi_rvalid && n < 60) begin tick(); n++; end
            chk("tmo_cycles", n, 32'd16);
            chk("tmo_rresp", {30'd0, axi_rresp}, 32'd2);
            chk("tmo_rdata", axi_rdata, 32'd0);
            response_enable = 1'b1; resp_data = 32'h99999999; tick(); response_enable = 1'b0;
            chk("tmo_late_rdata", axi_rdata, 32'd0);
            chk("tmo_late_rresp", {30'd0, axi_rresp}, 32'd2);
            r_hs();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
